// File: rtl/bsg_wormhole_network_test_node_master.sv
// Traffic master for the loopback test: sends numbered packets and checks the flits that come back.
// Latency: first flit is valid the cycle after en_i; done_o rises the cycle after the final flit returns.
// Backpressure: outgoing data is held while ready_and_rev is low; incoming flits are always accepted.
module bsg_wormhole_network_test_node_master #(
  parameter int flit_width_p        = 32,
  parameter int dims_p              = 2,
  parameter int cord_markers_pos_p [dims_p:0] = '{5, 4, 0},
  parameter int len_width_p         = 4,
  parameter int num_packets_width_p = 16,
  localparam int cord_width_lp      = cord_markers_pos_p[dims_p],
  localparam int link_width_lp      = flit_width_p + 2
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           en_i,
  input  logic [cord_width_lp-1:0]       my_cord_i,
  input  logic [cord_width_lp-1:0]       dest_cord_i,
  input  logic [len_width_p-1:0]         len_i,
  input  logic [num_packets_width_p-1:0] num_packets_i,
  input  logic [link_width_lp-1:0]       link_i,
  output logic [link_width_lp-1:0]       link_o,
  output logic [num_packets_width_p-1:0] sent_count_o,
  output logic [num_packets_width_p-1:0] recv_count_o,
  output logic                           error_o,
  output logic                           done_o
);

  localparam int dw_lp = flit_width_p - cord_width_lp - len_width_p;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_e;

  state_e                         state_r, state_n;
  logic [len_width_p-1:0]         len_r;
  logic [num_packets_width_p-1:0] num_r;
  logic [num_packets_width_p-1:0] tx_seq_r, rx_seq_r;
  logic [len_width_p-1:0]         tx_idx_r, rx_idx_r;
  logic [num_packets_width_p-1:0] sent_r, recv_r, recv_next;
  logic                           error_r;

  // Link fields are packed {v, data, ready_and_rev}, v in the MSB.
  logic                    in_v, in_ready, out_v;
  logic [flit_width_p-1:0] in_data, out_data, rx_expect;
  logic [dw_lp-1:0]        tx_payload, rx_payload;

  assign in_v     = link_i[link_width_lp-1];
  assign in_data  = link_i[link_width_lp-2:1];
  assign in_ready = link_i[0];

  // Payload is the low bits of {seq, idx}; a pure function of registers so it is stall-stable.
  assign tx_payload = dw_lp'({tx_seq_r, tx_idx_r});
  assign rx_payload = dw_lp'({rx_seq_r, rx_idx_r});
  assign out_data   = {tx_payload, len_r, dest_cord_i};
  assign rx_expect  = {rx_payload, len_r, my_cord_i};
  assign link_o     = {out_v, out_data, 1'b1};

  logic tx_fire, tx_last, rx_active, rx_take, rx_pkt_end;

  assign tx_fire    = out_v & in_ready;
  assign tx_last    = (tx_idx_r == len_r);
  // Flits are only expected while running and before every packet has come back.
  assign rx_active  = ((state_r == SEND) || (state_r == WAIT)) && (recv_r != num_r);
  assign rx_take    = in_v & rx_active;
  assign rx_pkt_end = rx_take & (rx_idx_r == len_r);
  assign recv_next  = recv_r + num_packets_width_p'(rx_pkt_end);

  // State register.
  always_ff @(posedge clk_i) begin
    if (!reset_i) state_r <= IDLE;
    else          state_r <= state_n;
  end

  // Next-state and per-state outputs; WAIT looks at recv_next so done_o follows the last flit by one cycle.
  always_comb begin
    state_n = state_r;
    out_v   = 1'b0;
    done_o  = 1'b0;
    case (state_r)
      IDLE: begin
        if (en_i) state_n = (num_packets_i == '0) ? DONE : SEND;
      end
      SEND: begin
        out_v = 1'b1;
        if (tx_fire && tx_last && ((sent_r + num_packets_width_p'(1)) == num_r)) state_n = WAIT;
      end
      WAIT: begin
        if (recv_next == num_r) state_n = DONE;
      end
      DONE: begin
        done_o = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Run parameters, TX/RX counters and the sticky error flag; TX and RX advance independently.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      len_r    <= '0;
      num_r    <= '0;
      tx_seq_r <= '0;
      tx_idx_r <= '0;
      rx_seq_r <= '0;
      rx_idx_r <= '0;
      sent_r   <= '0;
      recv_r   <= '0;
      error_r  <= 1'b0;
    end else begin
      if (state_r == IDLE && en_i) begin
        len_r    <= len_i;
        num_r    <= num_packets_i;
        tx_seq_r <= '0;
        tx_idx_r <= '0;
        rx_seq_r <= '0;
        rx_idx_r <= '0;
        sent_r   <= '0;
        recv_r   <= '0;
      end else begin
        if (tx_fire) begin
          if (tx_last) begin
            tx_idx_r <= '0;
            tx_seq_r <= tx_seq_r + num_packets_width_p'(1);
            sent_r   <= sent_r + num_packets_width_p'(1);
          end else begin
            tx_idx_r <= tx_idx_r + len_width_p'(1);
          end
        end
        // A bad flit still advances the counters so the stream stays aligned.
        if (rx_take) begin
          if (rx_pkt_end) begin
            rx_idx_r <= '0;
            rx_seq_r <= rx_seq_r + num_packets_width_p'(1);
            recv_r   <= recv_next;
          end else begin
            rx_idx_r <= rx_idx_r + len_width_p'(1);
          end
        end
      end
      if (in_v && (!rx_active || (in_data != rx_expect))) error_r <= 1'b1;
    end
  end

  assign sent_count_o = sent_r;
  assign recv_count_o = recv_r;
  assign error_o      = error_r;

endmodule

// File: tb/tb_bsg_wormhole_network_test_node_master.sv
module tb_bsg_wormhole_network_test_node_master;

  localparam int FW = 32;
  localparam int LW = 4;
  localparam int NW = 16;
  localparam int CW = 5;
  localparam int TIMEOUT = 3000;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          en;
  logic [CW-1:0] my_cord, dest_cord;
  logic [LW-1:0] len;
  logic [NW-1:0] num;
  logic [FW+1:0] link_i, link_o;
  logic [NW-1:0] sent_count, recv_count;
  logic          error, done;

  logic          in_v, in_rdy;
  logic [FW-1:0] in_data;
  logic          out_v, out_rev;
  logic [FW-1:0] out_data;

  assign link_i   = {in_v, in_data, in_rdy};
  assign out_v    = link_o[FW+1];
  assign out_data = link_o[FW:1];
  assign out_rev  = link_o[0];

  always #5 clk = ~clk;

  bsg_wormhole_network_test_node_master #(
    .flit_width_p(FW),
    .len_width_p(LW),
    .num_packets_width_p(NW)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_n),
    .en_i(en),
    .my_cord_i(my_cord),
    .dest_cord_i(dest_cord),
    .len_i(len),
    .num_packets_i(num),
    .link_i(link_i),
    .link_o(link_o),
    .sent_count_o(sent_count),
    .recv_count_o(recv_count),
    .error_o(error),
    .done_o(done)
  );

  int errors = 0;
  int checks = 0;

  logic [FW-1:0] net_q[$];
  logic [FW-1:0] exp_q[$];

  bit random_rdy  = 1'b0;
  bit inject      = 1'b0;
  int corrupt_at  = -1;
  int rx_cnt      = 0;
  int tx_cnt      = 0;
  int exp_rx_total = -1;
  bit v_seen      = 1'b0;

  // Expected flit: {pad, payload = {seq, idx}, len, cord}
  function automatic logic [FW-1:0] mk_flit(logic [CW-1:0] c, logic [LW-1:0] l,
                                            logic [NW-1:0] seq, logic [LW-1:0] idx);
    logic [NW+LW-1:0] p;
    p = {seq, idx};
    return {3'b000, p, l, c};
  endfunction

  // Loopback client and scoreboard: runs 1ns after each falling edge.
  initial begin
    bit            prev_tx_fire, prev_rx_fire, prev_from_q, prev_stall, prev_corrupt;
    logic [FW-1:0] prev_out, e;
    prev_tx_fire = 0; prev_rx_fire = 0; prev_from_q = 0; prev_stall = 0; prev_corrupt = 0;
    prev_out = '0;
    in_v = 1'b0; in_data = '0; in_rdy = 1'b1;
    forever begin
      @(negedge clk); #1;
      if (prev_tx_fire) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL tx_extra: got %h, none expected", prev_out);
        end else begin
          e = exp_q.pop_front();
          if (prev_out !== e) begin
            errors++; $display("FAIL tx_flit: got %h expected %h", prev_out, e);
          end
        end
        net_q.push_back({prev_out[FW-1:CW], my_cord});
        tx_cnt++;
      end
      if (prev_rx_fire && prev_from_q) begin
        void'(net_q.pop_front());
        rx_cnt++;
        if (rx_cnt == exp_rx_total) begin
          checks++;
          if (done !== 1'b1) begin
            errors++; $display("FAIL done_timing: done=%b expected 1", done);
          end
        end
      end
      if (prev_corrupt) begin
        checks++;
        if (error !== 1'b1) begin
          errors++; $display("FAIL error_timing: error=%b expected 1", error);
        end
      end
      if (prev_stall) begin
        checks++;
        if (out_v !== 1'b1 || out_data !== prev_out) begin
          errors++; $display("FAIL stall_hold: v=%b data=%h expected v=1 data=%h", out_v, out_data, prev_out);
        end
      end
      if (out_v) v_seen = 1'b1;

      in_rdy = random_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      prev_corrupt = 0;
      prev_from_q  = 0;
      if (inject) begin
        in_v = 1'b1; in_data = mk_flit(my_cord, len, 16'hbeef, '0); inject = 1'b0;
      end else if (net_q.size() > 0) begin
        in_v = 1'b1; in_data = net_q[0]; prev_from_q = 1;
        if (rx_cnt == corrupt_at) begin
          in_data[20] = ~in_data[20];
          prev_corrupt = 1;
          checks++;
          if (error !== 1'b0) begin
            errors++; $display("FAIL error_early: error=%b expected 0", error);
          end
        end
      end else begin
        in_v = 1'b0; in_data = '0;
      end
      prev_tx_fire = out_v & in_rdy;
      prev_stall   = out_v & ~in_rdy;
      prev_out     = out_data;
      prev_rx_fire = in_v;
    end
  end

  // Hold reset until the loopback network has drained.
  task automatic do_reset();
    int t;
    @(negedge clk);
    reset_n = 1'b0;
    en = 1'b0;
    exp_rx_total = -1;
    repeat (2) @(negedge clk);
    t = 0;
    while (net_q.size() > 0 && t < TIMEOUT) begin @(negedge clk); t++; end
    if (t >= TIMEOUT) begin errors++; $display("FAIL drain_timeout: net_q=%0d required 0", net_q.size()); end
    repeat (2) @(negedge clk);
    exp_q.delete();
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic start_run(int n, int l);
    for (int s = 0; s < n; s++)
      for (int i = 0; i <= l; i++)
        exp_q.push_back(mk_flit(dest_cord, LW'(l), NW'(s), LW'(i)));
    num = NW'(n);
    len = LW'(l);
    rx_cnt = 0;
    tx_cnt = 0;
    v_seen = 1'b0;
    exp_rx_total = n * (l + 1);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    checks++;
    if (n > 0) begin
      if (out_v !== 1'b1) begin errors++; $display("FAIL first_flit: v=%b expected 1", out_v); end
    end else begin
      if (done !== 1'b1) begin errors++; $display("FAIL zero_done: done=%b expected 1", done); end
    end
  endtask

  task automatic wait_done(output bit ok);
    int t;
    t = 0;
    while (done !== 1'b1 && t < TIMEOUT) begin @(negedge clk); t++; end
    ok = (done === 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; en = 1'b0;
    repeat (3) @(negedge clk);
    checks += 6;
    if (out_v !== 1'b0)    begin errors++; $display("FAIL reset_v: got %b required 0", out_v); end
    if (out_rev !== 1'b1)  begin errors++; $display("FAIL reset_rev: got %b required 1", out_rev); end
    if (sent_count !== '0) begin errors++; $display("FAIL reset_sent: got %0d required 0", sent_count); end
    if (recv_count !== '0) begin errors++; $display("FAIL reset_recv: got %0d required 0", recv_count); end
    if (error !== 1'b0)    begin errors++; $display("FAIL reset_error: got %b required 0", error); end
    if (done !== 1'b0)     begin errors++; $display("FAIL reset_done: got %b required 0", done); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    start_run(1, 0);
    wait_done(ok);
    checks += 5;
    if (!ok)               begin errors++; $display("FAIL single_timeout: done=%b required 1", done); end
    if (sent_count !== 1)  begin errors++; $display("FAIL single_sent: got %0d required 1", sent_count); end
    if (recv_count !== 1)  begin errors++; $display("FAIL single_recv: got %0d required 1", recv_count); end
    if (error !== 1'b0)    begin errors++; $display("FAIL single_error: got %b required 0", error); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL single_unsent: %0d flits left, required 0", exp_q.size()); end
  endtask

  task automatic test_multi();
    bit ok;
    do_reset();
    start_run(3, 2);
    wait_done(ok);
    checks += 5;
    if (!ok)               begin errors++; $display("FAIL multi_timeout: done=%b required 1", done); end
    if (sent_count !== 3)  begin errors++; $display("FAIL multi_sent: got %0d required 3", sent_count); end
    if (recv_count !== 3)  begin errors++; $display("FAIL multi_recv: got %0d required 3", recv_count); end
    if (error !== 1'b0)    begin errors++; $display("FAIL multi_error: got %b required 0", error); end
    if (tx_cnt != 9)       begin errors++; $display("FAIL multi_flits: got %0d required 9", tx_cnt); end
  endtask

  task automatic test_stall();
    bit ok;
    do_reset();
    random_rdy = 1'b1;
    start_run(8, 3);
    wait_done(ok);
    random_rdy = 1'b0;
    checks += 5;
    if (!ok)               begin errors++; $display("FAIL stall_timeout: done=%b required 1", done); end
    if (sent_count !== 8)  begin errors++; $display("FAIL stall_sent: got %0d required 8", sent_count); end
    if (recv_count !== 8)  begin errors++; $display("FAIL stall_recv: got %0d required 8", recv_count); end
    if (error !== 1'b0)    begin errors++; $display("FAIL stall_error: got %b required 0", error); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL stall_unsent: %0d flits left, required 0", exp_q.size()); end
  endtask

  task automatic test_corrupt();
    bit ok;
    do_reset();
    corrupt_at = 4;
    start_run(2, 3);
    wait_done(ok);
    repeat (5) @(negedge clk);
    corrupt_at = -1;
    checks += 4;
    if (!ok)              begin errors++; $display("FAIL corrupt_timeout: done=%b required 1", done); end
    if (recv_count !== 2) begin errors++; $display("FAIL corrupt_recv: got %0d required 2", recv_count); end
    if (sent_count !== 2) begin errors++; $display("FAIL corrupt_sent: got %0d required 2", sent_count); end
    if (error !== 1'b1)   begin errors++; $display("FAIL corrupt_sticky: got %b required 1", error); end
  endtask

  task automatic test_zero();
    do_reset();
    start_run(0, 2);
    repeat (5) @(negedge clk);
    checks += 3;
    if (v_seen !== 1'b0) begin errors++; $display("FAIL zero_v: link_o.v seen=%b required 0", v_seen); end
    if (error !== 1'b0)  begin errors++; $display("FAIL zero_error_pre: got %b required 0", error); end
    if (done !== 1'b1)   begin errors++; $display("FAIL zero_done_hold: got %b required 1", done); end
    inject = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (error !== 1'b1)  begin errors++; $display("FAIL stray_error: got %b required 1", error); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int t;
    do_reset();
    start_run(4, 3);
    t = 0;
    while (tx_cnt < 5 && t < TIMEOUT) begin @(negedge clk); t++; end
    checks++;
    if (tx_cnt < 5) begin errors++; $display("FAIL mid_progress: sent flits %0d required 5", tx_cnt); end
    exp_rx_total = -1;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    t = 0;
    while (net_q.size() > 0 && t < TIMEOUT) begin @(negedge clk); t++; end
    @(negedge clk);
    checks += 6;
    if (out_v !== 1'b0)    begin errors++; $display("FAIL mid_v: got %b required 0", out_v); end
    if (out_rev !== 1'b1)  begin errors++; $display("FAIL mid_rev: got %b required 1", out_rev); end
    if (sent_count !== '0) begin errors++; $display("FAIL mid_sent: got %0d required 0", sent_count); end
    if (recv_count !== '0) begin errors++; $display("FAIL mid_recv: got %0d required 0", recv_count); end
    if (error !== 1'b0)    begin errors++; $display("FAIL mid_error: got %b required 0", error); end
    if (done !== 1'b0)     begin errors++; $display("FAIL mid_done: got %b required 0", done); end
    exp_q.delete();
    reset_n = 1'b1;
    @(negedge clk);
    start_run(2, 1);
    wait_done(ok);
    checks += 4;
    if (!ok)              begin errors++; $display("FAIL rerun_timeout: done=%b required 1", done); end
    if (sent_count !== 2) begin errors++; $display("FAIL rerun_sent: got %0d required 2", sent_count); end
    if (recv_count !== 2) begin errors++; $display("FAIL rerun_recv: got %0d required 2", recv_count); end
    if (error !== 1'b0)   begin errors++; $display("FAIL rerun_error: got %b required 0", error); end
  endtask

  initial begin
    reset_n   = 1'b0;
    en        = 1'b0;
    my_cord   = 5'h03;
    dest_cord = 5'h11;
    len       = '0;
    num       = '0;
    test_reset();
    test_single();
    test_multi();
    test_stall();
    test_corrupt();
    test_zero();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
